module_acc_1x8: RTL and testbench

//  8-lane int4 multiply-accumulate stage feeding module_quant_1x8 one-to-one (acc_result_0..7).

---
 rtl/module_acc_1x8_pkg.sv | 35 +++
 rtl/module_acc_1x8_mac_lane.sv | 48 ++++
 rtl/module_acc_1x8.sv | 122 ++++++++++++
 tb/tb_module_acc_1x8.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/module_acc_1x8_pkg.sv
// Shared widths, limits and FSM encoding for the 8-lane int4 MAC stage.
// Also provides the accumulator clamp helper used by each lane.
package module_acc_1x8_pkg;

    localparam int ACT_W     = 4;
    localparam int WGT_W     = 4;
    localparam int ACC_W     = 15;
    localparam int MAX_TERMS = 128;
    localparam int CNT_W     = 8;
    localparam int PROD_W    = ACT_W + WGT_W + 1;
    localparam int N_LANES   = 8;

    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX_TERMS = CNT_W'(MAX_TERMS);

    // One extra bit of headroom so a single add never wraps before the clamp.
    localparam logic signed [ACC_W:0] ACC_HI = (ACC_W+1)'((2**(ACC_W-1)) - 1);
    localparam logic signed [ACC_W:0] ACC_LO = (ACC_W+1)'(-(2**(ACC_W-1)));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FLUSH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        logic signed [ACC_W:0] c;
        c = v;
        if (v > ACC_HI) c = ACC_HI;
        else if (v < ACC_LO) c = ACC_LO;
        return c[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/module_acc_1x8_mac_lane.sv
// One output channel: registered zero-point-corrected product, then a
// saturating accumulate whose clamp flag pulses on the clamping update.
module module_acc_1x8_mac_lane
    import module_acc_1x8_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_accept,
    input  logic [ACT_W-1:0]        i_act,
    input  logic [ACT_W-1:0]        i_zp,
    input  logic signed [WGT_W-1:0] i_wgt,
    input  logic                    i_s1_valid,
    input  logic                    i_s1_first,
    output logic signed [ACC_W-1:0] o_acc,
    output logic                    o_clamp
);

    logic signed [ACT_W:0]    w_act_off;
    logic signed [PROD_W-1:0] w_act_ext;
    logic signed [PROD_W-1:0] w_wgt_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W:0]    w_base;
    logic signed [ACC_W:0]    w_sum;
    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_act_off = $signed({1'b0, i_act}) - $signed({1'b0, i_zp});
    assign w_act_ext = {{(PROD_W-ACT_W-1){w_act_off[ACT_W]}}, w_act_off};
    assign w_wgt_ext = {{(PROD_W-WGT_W){i_wgt[WGT_W-1]}}, i_wgt};
    assign w_prod    = w_act_ext * w_wgt_ext;

    // The first beat of a packet restarts from zero, so nothing carries over.
    assign w_base  = i_s1_first ? '0 : {r_acc[ACC_W-1], r_acc};
    assign w_sum   = w_base + {{(ACC_W+1-PROD_W){r_prod[PROD_W-1]}}, r_prod};
    assign o_clamp = i_s1_valid && ((w_sum > ACC_HI) || (w_sum < ACC_LO));
    assign o_acc   = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            if (i_accept) r_prod <= w_prod;
            if (i_s1_valid) r_acc <= sat_acc(w_sum);
        end
    end

endmodule

// File: rtl/module_acc_1x8.sv
// 8-lane int4 dot-product accumulator: packet FSM, term counter, overflow
// latch and valid/ready handshakes around eight MAC lanes.
module module_acc_1x8
    import module_acc_1x8_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ACT_W-1:0]        i_act_zero_point,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic                    i_in_last,
    input  logic [ACT_W-1:0]        i_act,
    input  logic signed [WGT_W-1:0] i_wgt_0,
    input  logic signed [WGT_W-1:0] i_wgt_1,
    input  logic signed [WGT_W-1:0] i_wgt_2,
    input  logic signed [WGT_W-1:0] i_wgt_3,
    input  logic signed [WGT_W-1:0] i_wgt_4,
    input  logic signed [WGT_W-1:0] i_wgt_5,
    input  logic signed [WGT_W-1:0] i_wgt_6,
    input  logic signed [WGT_W-1:0] i_wgt_7,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic signed [ACC_W-1:0] o_acc_result_0,
    output logic signed [ACC_W-1:0] o_acc_result_1,
    output logic signed [ACC_W-1:0] o_acc_result_2,
    output logic signed [ACC_W-1:0] o_acc_result_3,
    output logic signed [ACC_W-1:0] o_acc_result_4,
    output logic signed [ACC_W-1:0] o_acc_result_5,
    output logic signed [ACC_W-1:0] o_acc_result_6,
    output logic signed [ACC_W-1:0] o_acc_result_7,
    output logic                    o_ovf
);

    state_t                  r_state, w_state_next;
    logic                    r_rdy_en;
    logic                    r_s1_valid, r_s1_first;
    logic                    r_out_valid, r_ovf;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;
    logic                    w_accept, w_out_hs, w_first;
    logic signed [WGT_W-1:0] w_wgt   [N_LANES];
    logic signed [ACC_W-1:0] w_acc   [N_LANES];
    logic [N_LANES-1:0]      w_clamp;

    assign w_wgt[0] = i_wgt_0;
    assign w_wgt[1] = i_wgt_1;
    assign w_wgt[2] = i_wgt_2;
    assign w_wgt[3] = i_wgt_3;
    assign w_wgt[4] = i_wgt_4;
    assign w_wgt[5] = i_wgt_5;
    assign w_wgt[6] = i_wgt_6;
    assign w_wgt[7] = i_wgt_7;

    // r_rdy_en is cleared by reset so in_ready is low while rst is asserted.
    assign o_in_ready  = r_rdy_en && ((r_state == S_IDLE) || (r_state == S_ACC));
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_first     = (r_state == S_IDLE);
    assign w_out_hs    = r_out_valid && i_out_ready;
    assign o_out_valid = r_out_valid;
    assign o_ovf       = r_ovf;
    assign w_cnt_next  = w_first ? CNT_ONE : ((r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_ACC: if (w_accept) w_state_next = i_in_last ? S_FLUSH : S_ACC;
            S_FLUSH:       w_state_next = S_HOLD;
            S_HOLD:        if (w_out_hs) w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rdy_en    <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rdy_en    <= 1'b1;
            r_s1_valid  <= w_accept;
            r_s1_first  <= w_first;
            // Results settle one edge after FLUSH, so valid trails HOLD entry by a cycle.
            r_out_valid <= (r_state == S_HOLD) && !w_out_hs;
            if (w_accept) r_cnt <= w_cnt_next;
            if (w_accept && w_first)
                r_ovf <= 1'b0;
            else if ((w_accept && (w_cnt_next > CNT_MAX_TERMS)) || (|w_clamp))
                r_ovf <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            module_acc_1x8_mac_lane u_lane (
                .clk        (clk),
                .rst        (rst),
                .i_accept   (w_accept),
                .i_act      (i_act),
                .i_zp       (i_act_zero_point),
                .i_wgt      (w_wgt[gi]),
                .i_s1_valid (r_s1_valid),
                .i_s1_first (r_s1_first),
                .o_acc      (w_acc[gi]),
                .o_clamp    (w_clamp[gi])
            );
        end
    endgenerate

    assign o_acc_result_0 = w_acc[0];
    assign o_acc_result_1 = w_acc[1];
    assign o_acc_result_2 = w_acc[2];
    assign o_acc_result_3 = w_acc[3];
    assign o_acc_result_4 = w_acc[4];
    assign o_acc_result_5 = w_acc[5];
    assign o_acc_result_6 = w_acc[6];
    assign o_acc_result_7 = w_acc[7];

endmodule

// File: tb/tb_module_acc_1x8.sv
// Directed scenario bench for module_acc_1x8; expected sums are hand-computed.
module tb_module_acc_1x8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] zp = '0;
    logic [3:0] act = '0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] wpk = '0;
    logic in_ready, out_valid, ovf;
    logic signed [14:0] acc_r [8];

    int cyc = 0;
    int last_edge = 0;
    int latency = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    module_acc_1x8 dut (
        .clk              (clk),
        .rst              (rst),
        .i_act_zero_point (zp),
        .i_in_valid       (in_valid),
        .o_in_ready       (in_ready),
        .i_in_last        (in_last),
        .i_act            (act),
        .i_wgt_0          (wpk[3:0]),
        .i_wgt_1          (wpk[7:4]),
        .i_wgt_2          (wpk[11:8]),
        .i_wgt_3          (wpk[15:12]),
        .i_wgt_4          (wpk[19:16]),
        .i_wgt_5          (wpk[23:20]),
        .i_wgt_6          (wpk[27:24]),
        .i_wgt_7          (wpk[31:28]),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_acc_result_0   (acc_r[0]),
        .o_acc_result_1   (acc_r[1]),
        .o_acc_result_2   (acc_r[2]),
        .o_acc_result_3   (acc_r[3]),
        .o_acc_result_4   (acc_r[4]),
        .o_acc_result_5   (acc_r[5]),
        .o_acc_result_6   (acc_r[6]),
        .o_acc_result_7   (acc_r[7]),
        .o_ovf            (ovf)
    );

    // Drives n beats starting at a negedge; returns at the negedge after the last accept.
    task automatic send_packet(input int n, input logic [3:0] a, input logic [3:0] z, input logic [31:0] wp);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 1000) begin
            in_valid = 1'b1; act = a; zp = z; wpk = wp;
            in_last = (sent == n - 1);
            if (in_ready) sent++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        last_edge = cyc;
        if (sent < n) begin
            n_total++;
            $display("FAIL send_timeout: sent %0d beats, required %0d", sent, n);
        end
    endtask

    task automatic wait_result();
        latency = -1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                latency = cyc - last_edge;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++;
        if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== 15'sd0) $display("FAIL rst_acc lane%0d: got %0d want 0", i, acc_r[i]); else n_pass++;
        end
        consume();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL idle_out_ready: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        send_packet(9, 4'd1, 4'd0, 32'h1111_1111);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL t1_early_valid: got %b want 0", out_valid); else n_pass++;
        wait_result();
        n_total++;
        if (latency !== 2) $display("FAIL t1_latency: got %0d want 2", latency); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== 15'sd9) $display("FAIL t1_acc lane%0d: got %0d want 9", i, acc_r[i]); else n_pass++;
        end
        n_total++;
        if (ovf !== 1'b0) $display("FAIL t1_ovf: got %b want 0", ovf); else n_pass++;
        consume();
        send_packet(1, 4'd3, 4'd0, 32'h2222_2222);
        wait_result();
        n_total++;
        if (latency !== 2) $display("FAIL t1b_latency: got %0d want 2", latency); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== 15'sd6) $display("FAIL t1b_acc lane%0d: got %0d want 6", i, acc_r[i]); else n_pass++;
        end
        consume();
    endtask

    task automatic test_long_packet();
        int exp_v [8];
        // (15-0)*-8*128 = -15360, (15-0)*7*128 = 13440
        exp_v = '{-15360, 13440, 0, 0, 0, 0, 0, 0};
        send_packet(128, 4'd15, 4'd0, 32'h0000_0078);
        wait_result();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== 15'(exp_v[i])) $display("FAIL t2_acc lane%0d: got %0d want %0d", i, acc_r[i], exp_v[i]);
            else n_pass++;
        end
        n_total++;
        if (ovf !== 1'b0) $display("FAIL t2_ovf: got %b want 0", ovf); else n_pass++;
        consume();
    endtask

    task automatic test_zero_point();
        send_packet(3, 4'd0, 4'd8, 32'h8888_8888);
        wait_result();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== 15'sd192) $display("FAIL t3_acc lane%0d: got %0d want 192", i, acc_r[i]); else n_pass++;
        end
        consume();
    endtask

    task automatic test_backpressure();
        send_packet(4, 4'd2, 4'd0, 32'h3333_3333);
        wait_result();
        in_valid = 1'b1; in_last = 1'b1; act = 4'd15;
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ovf !== 1'b0)
                $display("FAIL t4_hold cyc%0d: got valid=%b ready=%b ovf=%b want 1/0/0", k, out_valid, in_ready, ovf);
            else n_pass++;
            n_total++;
            if (acc_r[0] !== 15'sd24 || acc_r[7] !== 15'sd24)
                $display("FAIL t4_hold_acc cyc%0d: got %0d/%0d want 24", k, acc_r[0], acc_r[7]);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL t4_release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else n_pass++;
        in_valid = 1'b0; in_last = 1'b0;
        send_packet(2, 4'd1, 4'd0, 32'h1111_1111);
        wait_result();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== 15'sd2) $display("FAIL t4_next_acc lane%0d: got %0d want 2", i, acc_r[i]); else n_pass++;
        end
        consume();
    endtask

    task automatic test_saturation();
        send_packet(140, 4'd15, 4'd0, 32'h8888_8888);
        wait_result();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== -15'sd16384) $display("FAIL t5_acc lane%0d: got %0d want -16384", i, acc_r[i]); else n_pass++;
        end
        n_total++;
        if (ovf !== 1'b1) $display("FAIL t5_ovf: got %b want 1", ovf); else n_pass++;
        consume();
        send_packet(1, 4'd1, 4'd0, 32'h1111_1111);
        wait_result();
        n_total++;
        if (ovf !== 1'b0) $display("FAIL t5_ovf_clear: got %b want 0", ovf); else n_pass++;
        n_total++;
        if (acc_r[3] !== 15'sd1) $display("FAIL t5_next_acc: got %0d want 1", acc_r[3]); else n_pass++;
        consume();
    endtask

    task automatic test_reset_mid();
        int sent = 0;
        int guard = 0;
        while (sent < 5 && guard < 100) begin
            in_valid = 1'b1; act = 4'd1; zp = 4'd0; wpk = 32'h1111_1111; in_last = 1'b0;
            if (in_ready) sent++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (acc_r[0] !== 15'sd5) $display("FAIL t6_partial: got %0d want 5", acc_r[0]); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL t6_in_rst: got ready=%b valid=%b want 0/0", in_ready, out_valid);
        else n_pass++;
        n_total++;
        if (acc_r[0] !== 15'sd0) $display("FAIL t6_rst_acc: got %0d want 0", acc_r[0]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_packet(2, 4'd1, 4'd0, 32'h1111_1111);
        wait_result();
        n_total++;
        if (latency !== 2) $display("FAIL t6_latency: got %0d want 2", latency); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (acc_r[i] !== 15'sd2) $display("FAIL t6_acc lane%0d: got %0d want 2", i, acc_r[i]); else n_pass++;
        end
        consume();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_long_packet();
        test_zero_point();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
